gate_vector_driver: RTL and testbench

//   Synthesizable stimulus/check stage sitting directly upstream of an N-input

---
 rtl/gate_vector_driver_if.sv | 25 ++
 rtl/gate_vector_driver.sv | 118 +++++++++++
 tb/tb_gate_vector_driver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_vector_driver_if.sv
// Bundles the sweep control/status and gate-facing signals of gate_vector_driver.
// master is the driver side; slave is the controller/gate side.
interface gate_vector_driver_if #(
  parameter int N_INPUTS = 3
);
  logic                start;
  logic [N_INPUTS-1:0] dut_i;
  logic                dut_o;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   err_count;
  logic                first_fail_vld;
  logic [N_INPUTS-1:0] first_fail_vec;

  modport master (
    input  start, dut_o,
    output dut_i, busy, done, pass, err_count, first_fail_vld, first_fail_vec
  );

  modport slave (
    output start, dut_o,
    input  dut_i, busy, done, pass, err_count, first_fail_vld, first_fail_vec
  );
endinterface

// File: rtl/gate_vector_driver.sv
// Sweeps every input vector of an N-input combinational gate, holding each for
// HOLD_CYCLES clocks, and checks the gate output against TRUTH_TABLE.
module gate_vector_driver #(
  parameter int                     N_INPUTS    = 3,
  parameter int                     HOLD_CYCLES = 4,
  parameter logic [2**N_INPUTS-1:0] TRUTH_TABLE = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_vector_driver_if.master  bus
);

  localparam int                HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST = {N_INPUTS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [N_INPUTS-1:0] vec;
  logic [HW-1:0]       hold;
  logic [N_INPUTS:0]   err_count;
  logic                first_fail_vld;
  logic [N_INPUTS-1:0] first_fail_vec;
  logic                done;
  logic                pass;

  logic                start_sweep;
  logic                compare_edge;
  logic                last_vec;
  logic                mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    start_sweep  = 1'b0;
    compare_edge = 1'b0;
    last_vec     = (vec == VEC_LAST);
    mismatch     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          start_sweep = 1'b1;
          next_state  = DRIVE;
        end
      end
      DRIVE: begin
        compare_edge = (hold == HOLD_LAST);
        // dut_o only matters on the compare edge; earlier hold cycles are settle time
        mismatch     = compare_edge && (bus.dut_o != TRUTH_TABLE[vec]);
        if (compare_edge && last_vec) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      hold           <= '0;
      err_count      <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (start_sweep) begin
      vec            <= '0;
      hold           <= '0;
      err_count      <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else if (state == DRIVE) begin
      if (!compare_edge) begin
        hold <= hold + 1'b1;
      end else begin
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec;
          end
        end
        if (last_vec) begin
          done <= 1'b1;
          pass <= (err_count == '0) && !mismatch;
        end else begin
          vec  <= vec + 1'b1;
          hold <= '0;
        end
      end
    end
  end

  assign bus.dut_i          = vec;
  assign bus.busy           = (state == DRIVE);
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_count      = err_count;
  assign bus.first_fail_vld = first_fail_vld;
  assign bus.first_fail_vec = first_fail_vec;

endmodule

// File: tb/tb_gate_vector_driver.sv
// Directed bench for gate_vector_driver: one instance checks against AND3
// (8'h80), a second against OR3 (8'hFE), driving modelled gates.
module tb_gate_vector_driver;

  localparam int N     = 3;
  localparam int HOLD  = 4;
  localparam int SWEEP = 32;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_TIE1 = 2;
  localparam int G_TIE0 = 3;

  localparam int EV_NONE    = 0;
  localparam int EV_GLITCH  = 1;
  localparam int EV_REPULSE = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   mode_a;
  int   mode_b;
  logic glitch;
  logic sel;
  int   assertions = 0;
  int   failures   = 0;

  always #5 clk = ~clk;

  gate_vector_driver_if #(.N_INPUTS(N)) bus_a ();
  gate_vector_driver_if #(.N_INPUTS(N)) bus_b ();

  gate_vector_driver #(.N_INPUTS(N), .HOLD_CYCLES(HOLD), .TRUTH_TABLE(8'h80)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  gate_vector_driver #(.N_INPUTS(N), .HOLD_CYCLES(HOLD), .TRUTH_TABLE(8'hFE)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  function automatic logic gate(input int mode, input logic [N-1:0] v);
    case (mode)
      G_AND:   gate = &v;
      G_OR:    gate = |v;
      G_TIE1:  gate = 1'b1;
      default: gate = 1'b0;
    endcase
  endfunction

  // glitch flips dut_a's gate output during settle cycles only
  assign bus_a.dut_o = gate(mode_a, bus_a.dut_i) ^ glitch;
  assign bus_b.dut_o = gate(mode_b, bus_b.dut_i);

  logic [N-1:0] m_dut_i;
  logic         m_busy, m_done, m_pass, m_ffv;
  logic [N:0]   m_err;
  logic [N-1:0] m_ffvec;

  assign m_dut_i = sel ? bus_b.dut_i          : bus_a.dut_i;
  assign m_busy  = sel ? bus_b.busy           : bus_a.busy;
  assign m_done  = sel ? bus_b.done           : bus_a.done;
  assign m_pass  = sel ? bus_b.pass           : bus_a.pass;
  assign m_err   = sel ? bus_b.err_count      : bus_a.err_count;
  assign m_ffv   = sel ? bus_b.first_fail_vld : bus_a.first_fail_vld;
  assign m_ffvec = sel ? bus_b.first_fail_vec : bus_a.first_fail_vec;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic which);
    sel = which;
    @(negedge clk);
    if (which) bus_b.start = 1'b1;
    else       bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " dut_i"}, 32'(m_dut_i), 0);
    checkOutput({tag, " busy"},  32'(m_busy),  0);
    checkOutput({tag, " done"},  32'(m_done),  0);
    checkOutput({tag, " pass"},  32'(m_pass),  0);
    checkOutput({tag, " err"},   32'(m_err),   0);
    checkOutput({tag, " ffv"},   32'(m_ffv),   0);
    checkOutput({tag, " ffvec"}, 32'(m_ffvec), 0);
  endtask

  // Called right after applyStimulus: counts clocks from the start-sampling edge
  task automatic waitDone(input string tag, input int ev);
    int lat;
    lat = 0;
    for (int c = 1; c <= SWEEP + 8 && lat == 0; c++) begin
      if (ev == EV_GLITCH) glitch = ((c % HOLD) != 0);
      if (ev == EV_REPULSE && c == 14) bus_a.start = 1'b1;
      if (ev == EV_REPULSE && c == 15) bus_a.start = 1'b0;
      @(negedge clk);
      if ((c % HOLD) == 0 && c < SWEEP)
        checkOutput({tag, " dut_i step"}, 32'(m_dut_i), 32'(c / HOLD));
      if (m_done) lat = c;
    end
    glitch      = 1'b0;
    bus_a.start = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), SWEEP);
  endtask

  task automatic checkResult(input string tag, input int err, input int ffv, input int ffvec, input int pass);
    checkOutput({tag, " done"},  32'(m_done),  1);
    checkOutput({tag, " busy"},  32'(m_busy),  0);
    checkOutput({tag, " dut_i"}, 32'(m_dut_i), 7);
    checkOutput({tag, " pass"},  32'(m_pass),  32'(pass));
    checkOutput({tag, " err"},   32'(m_err),   32'(err));
    checkOutput({tag, " ffv"},   32'(m_ffv),   32'(ffv));
    checkOutput({tag, " ffvec"}, 32'(m_ffvec), 32'(ffvec));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    mode_a      = G_AND;
    mode_b      = G_OR;
    glitch      = 1'b0;
    sel         = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleZero("reset a");
    sel = 1'b1;
    checkIdleZero("reset b");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] AND3 against 8'h80 with settle glitches");
    applyStimulus(1'b0);
    checkOutput("s1 busy", 32'(m_busy), 1);
    waitDone("s1", EV_GLITCH);
    checkResult("s1", 0, 0, 0, 1);

    $display("[TB] OR3 against 8'hFE");
    mode_b = G_OR;
    applyStimulus(1'b1);
    waitDone("s2", EV_NONE);
    checkResult("s2", 0, 0, 0, 1);

    $display("[TB] OR3 against 8'h80");
    mode_a = G_OR;
    applyStimulus(1'b0);
    waitDone("s3", EV_NONE);
    checkResult("s3", 6, 1, 1, 0);

    $display("[TB] tied outputs");
    mode_a = G_TIE1;
    applyStimulus(1'b0);
    waitDone("s4a", EV_NONE);
    checkResult("s4a", 7, 1, 0, 0);
    mode_b = G_TIE0;
    applyStimulus(1'b1);
    waitDone("s4b", EV_NONE);
    checkResult("s4b", 7, 1, 1, 0);

    $display("[TB] start ignored while sweeping, reset mid-sweep");
    mode_a = G_AND;
    applyStimulus(1'b0);
    waitDone("s5 repulse", EV_REPULSE);
    checkResult("s5 repulse", 0, 0, 0, 1);
    mode_a = G_TIE1;
    applyStimulus(1'b0);
    repeat (20) @(negedge clk);
    checkOutput("s5 pre-reset dut_i", 32'(m_dut_i), 5);
    checkOutput("s5 pre-reset err", 32'(m_err), 5);
    rst_n = 1'b0;
    #1;
    checkIdleZero("s5 reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleZero("s5 after release");
    mode_a = G_AND;
    applyStimulus(1'b0);
    waitDone("s5 fresh", EV_NONE);
    checkResult("s5 fresh", 0, 0, 0, 1);

    $display("[TB] restart from a failing DONE");
    mode_a = G_OR;
    applyStimulus(1'b0);
    waitDone("s6 fail", EV_NONE);
    checkResult("s6 fail", 6, 1, 1, 0);
    mode_a = G_AND;
    applyStimulus(1'b0);
    checkOutput("s6 restart err", 32'(m_err), 0);
    checkOutput("s6 restart ffv", 32'(m_ffv), 0);
    checkOutput("s6 restart done", 32'(m_done), 0);
    checkOutput("s6 restart busy", 32'(m_busy), 1);
    waitDone("s6 pass", EV_NONE);
    checkResult("s6 pass", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
